// File: rtl/edn_rr_arb.sv
// Round-robin arbiter sharing one EDN endpoint between NumReq consumers.
// Each grant is a burst of up to WordsPerReq words with an accumulated FIPS flag.
module edn_rr_arb #(
   parameter int NumReq      = 4,
   parameter int WordsPerReq = 4,
   parameter int BusW        = 32,
   localparam int IdxW       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NumReq-1:0] req_i,
   output logic [NumReq-1:0] valid_o,
   output logic              last_o,
   output logic [BusW-1:0]   data_o,
   output logic              fips_o,
   output logic [IdxW-1:0]   gnt_idx_o,
   output logic              edn_req_o,
   input  logic              edn_ack_i,
   input  logic [BusW-1:0]   edn_bus_i,
   input  logic              edn_fips_i
);

   localparam int CntW = (WordsPerReq > 1) ? $clog2(WordsPerReq) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WordsPerReq - 1);

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StBusy = 1'b1
   } state_e;

   state_e            state_r;
   logic [IdxW-1:0]   ptr_r;
   logic [CntW-1:0]   cnt_r;
   logic              fips_acc_r;

   logic              pick_vld_s;
   logic [IdxW-1:0]   pick_idx_s;
   logic [IdxW-1:0]   cand_s;
   logic              req_g_s;
   logic              fips_new_s;
   logic              cnt_last_s;
   logic [IdxW-1:0]   ptr_nxt_s;
   logic              busy_s;

   // Round-robin pick: first set request at or after the pointer, wrapping.
   always_comb begin
      pick_vld_s = 1'b0;
      pick_idx_s = {IdxW{1'b0}};
      cand_s     = {IdxW{1'b0}};
      for (int i = 0; i < NumReq; i++) begin
         cand_s = IdxW'((int'(ptr_r) + i) % NumReq);
         if (!pick_vld_s && req_i[cand_s]) begin
            pick_vld_s = 1'b1;
            pick_idx_s = cand_s;
         end else begin
            pick_vld_s = pick_vld_s;
         end
      end
   end

   assign req_g_s    = req_i[gnt_idx_o];
   assign fips_new_s = fips_acc_r & edn_fips_i;
   assign cnt_last_s = (cnt_r == CntLast);
   assign ptr_nxt_s  = IdxW'((int'(gnt_idx_o) + 32'sd1) % NumReq);
   assign busy_s     = (state_r == StBusy);

   // Arbitration FSM with registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r    <= StIdle;
         ptr_r      <= {IdxW{1'b0}};
         cnt_r      <= {CntW{1'b0}};
         fips_acc_r <= 1'b1;
         valid_o    <= {NumReq{1'b0}};
         last_o     <= 1'b0;
         data_o     <= {BusW{1'b0}};
         fips_o     <= 1'b1;
         edn_req_o  <= 1'b0;
         gnt_idx_o  <= {IdxW{1'b0}};
      end else begin
         valid_o <= {NumReq{1'b0}};
         last_o  <= 1'b0;
         case (state_r)
            StIdle: begin
               if (pick_vld_s) begin
                  gnt_idx_o  <= pick_idx_s;
                  cnt_r      <= {CntW{1'b0}};
                  fips_acc_r <= 1'b1;
                  edn_req_o  <= 1'b1;
                  state_r    <= StBusy;
               end
            end
            StBusy: begin
               if (edn_ack_i) begin
                  data_o              <= edn_bus_i;
                  fips_o              <= fips_new_s;
                  fips_acc_r          <= fips_new_s;
                  valid_o[gnt_idx_o]  <= req_g_s;
                  // An abandoned burst ends on the ack that was already owed.
                  if (cnt_last_s || !req_g_s) begin
                     last_o    <= req_g_s & cnt_last_s;
                     edn_req_o <= 1'b0;
                     ptr_r     <= ptr_nxt_s;
                     state_r   <= StIdle;
                  end else begin
                     cnt_r <= cnt_r + CntW'(1);
                  end
               end
            end
            default: begin
               edn_req_o <= 1'b0;
               state_r   <= StIdle;
            end
         endcase
      end
   end

   edn_rr_arb_chk #(.NumReq(NumReq)) u_chk (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .busy    (busy_s),
      .edn_ack (edn_ack_i),
      .edn_req (edn_req_o),
      .valid   (valid_o)
   );

endmodule

// Protocol checks for edn_rr_arb.
module edn_rr_arb_chk #(
   parameter int NumReq = 4
) (
   input logic              clk_i,
   input logic              rst_i,
   input logic              busy,
   input logic              edn_ack,
   input logic              edn_req,
   input logic [NumReq-1:0] valid
);

   a_ack_idle: assert property (@(posedge clk_i) disable iff (rst_i) !busy |-> !edn_ack);
   a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i) edn_req && !edn_ack |=> edn_req);
   a_onehot:   assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(valid));

endmodule
